stage4_r2sdf: RTL and testbench
===============================

Name: stage4_r2sdf

Overview:
- Fourth radix-2 single-path delay-feedback (SDF) stage of the 32-point DIF FFT pipeline.
- Sits directly downstream of stage 3 and consumes its 16-bit stream.
- Butterfly span 2: 2-deep feedback delay line, trivial twiddles {1, −j}, 17-bit output to stage 5.
- Owns its own sample counter, input register, drain FSM and registered outputs.

Parameters:
- IW, 16, input sample width (signed, per component).
- OW, 17, output width = IW+1.
- D, 2, feedback delay depth (butterfly span). Fixed; RTL may hard-code 2.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- valid_i  input  1  data_in_r/i hold a valid sample this cycle.
- data_in_r  input  16  signed real part from stage 3.
- data_in_i  input  16  signed imaginary part from stage 3.
- valid_o  output  1  data_out_r/i valid this cycle.
- data_out_r  output  17  signed real result.
- data_out_i  output  17  signed imaginary result.
- err_o  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst_n=0): input regs, delay line, cnt, outputs, err_o all cleared to 0; FSM to IDLE. Applies mid-frame; partial groups and pending diffs are discarded.
- Input stage: valid_i/data_in registered every cycle (vr, ar, ai). All processing uses registered values.
- cnt[1:0] advances by 1 on every processed step. A step occurs when vr=1, or when the FSM is in DRAIN.
- Phase = cnt[1].
  - Fill (cnt=0,1):
    - Delay line shifts in A (sign-extended to 17b); zero if the step is a drain step.
    - Delay head d is output multiplied by the twiddle: cnt=0 → ×1; cnt=1 → ×(−j), i.e. out_r=d_i, out_i=−d_r.
    - valid_o=1 only if the group holds real diffs (pending=1).
  - Butterfly (cnt=2,3):
    - B = delay head; output B+A with valid_o=1.
    - Delay line shifts in B−A.
- Arithmetic: all sums/diffs in 17 bits, no saturation or scaling. |B−A| ≤ 65535, so −d_r never overflows.
- pending: set at the step with cnt=3; cleared at the step with cnt=1 during fill.
- FSM:
  - IDLE: no pending diffs. vr=1 → RUN (step processed).
  - RUN: on cnt=0 with vr=0 and pending=1 → DRAIN (this cycle is drain step 1). On cnt=0 with vr=0 and pending=0 → IDLE.
  - DRAIN: the step at cnt=1 is performed unconditionally, then → IDLE with cnt=0, pending=0.
  - A vr=1 during a DRAIN cycle at cnt=1 is dropped and sets err_o.
  - vr=0 while cnt≠0 in RUN: stall (no step, valid_o=0). Also sets err_o, since upstream must deliver 4-sample groups contiguously.
- Latency: sample accepted at edge k affects outputs visible after edge k+1, i.e. sampled downstream at edge k+2.
- Outputs registered. valid_o=0 on any non-emitting cycle. data_out holds its last value when valid_o=0.
- err_o sticky until reset.
- Output order per 4-group x0..x3: x0+x2, x1+x3, x0−x2, (x1−x3)(−j). The diffs are emitted during the next group's fill or during drain.

Test Plan:
- Reset then 4 samples (1,0),(2,0),(3,0),(4,0) at edges 0–3, then idle → valid_o at edges 4,5,6,7: (4,0),(6,0),(−2,0),(0,2); then valid_o=0 and FSM back to IDLE; err_o=0.
- Continuous 32-sample frame of x_k=(k,−k) → 32 valid outputs with no gaps after the 2-cycle latency. Per group g, diff pair = (−2,2) then (2,2)×… i.e. (x1−x3)=(−2,2) → (2,2). Final two outputs come from drain.
- Extremes: A=(−32768,32767) at cnt 0,1, B=(32767,−32768) at cnt 2,3 → sum (−1,−1); diffs (−65535,65535) and twiddled (65535,65535); no wrap.
- Stall at cnt=1 (valid_i low one cycle mid-group) → one cycle with valid_o=0, err_o=1, and correct results once resumed.
- Drain followed by valid_i asserted in drain cycle 2 → that sample is dropped, err_o=1, both pending diffs still emitted correctly.
- Assert rst_n=0 mid-butterfly phase → outputs and err_o are 0 immediately (async). The next frame after release produces results uncontaminated by the old delay contents.

Source files
------------

// File: rtl/stage4_r2sdf.sv
// stage4_r2sdf: span-2 radix-2 SDF stage (twiddles 1, -j) of the 32-point DIF FFT
module stage4_r2sdf #(
  parameter int IW = 16,
  parameter int OW = IW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic signed [IW-1:0] data_in_r,
  input  logic signed [IW-1:0] data_in_i,
  output logic                 valid_o,
  output logic signed [OW-1:0] data_out_r,
  output logic signed [OW-1:0] data_out_i,
  output logic                 err_o
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic vr, pending, pending_nx, step, drain_step, emit, err_set;
  logic signed [IW-1:0] ar, ai;
  logic [1:0] cnt, cnt_nx;
  logic signed [OW-1:0] d0_r, d0_i, d1_r, d1_i, a_r, a_i, sh_r, sh_i, o_r, o_i;
  // register the incoming stream; all processing works on these copies
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vr <= 1'b0;
      ar <= '0;
      ai <= '0;
    end else begin
      vr <= valid_i;
      ar <= data_in_r;
      ai <= data_in_i;
    end
  // step qualification, butterfly / twiddle datapath and next-state decode
  always_comb begin
    drain_step = (state == DRAIN) || (state == RUN && !vr && cnt == 2'd0 && pending);
    step       = (vr && state != DRAIN) || drain_step;
    emit       = step && (cnt[1] || pending);
    err_set    = (state == DRAIN && vr) || (state == RUN && !vr && cnt != 2'd0);
    a_r        = drain_step ? '0 : OW'(ar);
    a_i        = drain_step ? '0 : OW'(ai);
    o_r        = cnt[1] ? d0_r + a_r : (cnt[0] ? d0_i : d0_r);
    o_i        = cnt[1] ? d0_i + a_i : (cnt[0] ? -d0_r : d0_i);
    sh_r       = cnt[1] ? d0_r - a_r : a_r;
    sh_i       = cnt[1] ? d0_i - a_i : a_i;
    cnt_nx     = state == DRAIN ? 2'd0 : cnt + 2'd1;
    pending_nx = cnt == 2'd3 ? 1'b1 : (cnt == 2'd1 ? 1'b0 : pending);
    state_nx   = state == IDLE  ? (vr ? RUN : IDLE) :
                 state == DRAIN ? IDLE :
                 (cnt == 2'd0 && !vr) ? (pending ? DRAIN : IDLE) : RUN;
  end
  // FSM, counter, delay line and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pending    <= 1'b0;
      d0_r       <= '0;
      d0_i       <= '0;
      d1_r       <= '0;
      d1_i       <= '0;
      valid_o    <= 1'b0;
      data_out_r <= '0;
      data_out_i <= '0;
      err_o      <= 1'b0;
    end else begin
      state   <= state_nx;
      valid_o <= emit;
      err_o   <= err_o | err_set;
      if (step) begin
        cnt     <= cnt_nx;
        pending <= pending_nx;
        d0_r    <= d1_r;
        d0_i    <= d1_i;
        d1_r    <= sh_r;
        d1_i    <= sh_i;
      end
      if (emit) begin
        data_out_r <= o_r;
        data_out_i <= o_i;
      end
    end
endmodule

// File: tb/tb_stage4_r2sdf.sv
// tb_stage4_r2sdf: directed/randomized self-checking bench for stage4_r2sdf
module tb_stage4_r2sdf;
  logic clk = 1'b0;
  logic rst_n, valid_i, valid_o, err_o;
  logic signed [15:0] data_in_r, data_in_i;
  logic signed [16:0] data_out_r, data_out_i;
  int tests = 0, fails = 0, emitted = 0;
  logic [33:0] expq[$];
  logic [63:0] vhist;
  logic signed [15:0] gr[4], gi[4];

  stage4_r2sdf dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i),
    .data_in_r(data_in_r), .data_in_i(data_in_i),
    .valid_o(valid_o), .data_out_r(data_out_r), .data_out_i(data_out_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [33:0] pk(input int r, input int i);
    return {17'(r), 17'(i)};
  endfunction

  // expected stream of one 4-sample group: x0+x2, x1+x3, x0-x2, (x1-x3)*(-j)
  task automatic model_group();
    int xr[4], xi[4];
    foreach (xr[k]) begin
      xr[k] = gr[k];
      xi[k] = gi[k];
    end
    expq.push_back(pk(xr[0] + xr[2], xi[0] + xi[2]));
    expq.push_back(pk(xr[1] + xr[3], xi[1] + xi[3]));
    expq.push_back(pk(xr[0] - xr[2], xi[0] - xi[2]));
    expq.push_back(pk(xi[1] - xi[3], -(xr[1] - xr[3])));
  endtask

  task automatic rand_group();
    foreach (gr[k]) begin
      gr[k] = 16'($urandom);
      gi[k] = 16'($urandom);
    end
    model_group();
  endtask

  task automatic cyc(input logic v, input logic signed [15:0] r, input logic signed [15:0] i);
    valid_i = v;
    data_in_r = r;
    data_in_i = i;
    @(posedge clk);
    #1;
    vhist = {vhist[62:0], valid_o};
    if (valid_o) begin
      emitted++;
      tests++;
      assert (expq.size() != 0) else begin
        fails++;
        $error("FAIL extra_out observed=%0h expected=none", {data_out_r, data_out_i});
      end
      if (expq.size() != 0) chk("out_data", {data_out_r, data_out_i}, expq.pop_front());
    end
  endtask

  task automatic send_group();
    for (int k = 0; k < 4; k++) cyc(1'b1, gr[k], gi[k]);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid_i = 1'b0;
    expq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    valid_i = 1'b0;
    data_in_r = '0;
    data_in_i = '0;
    vhist = '0;
    #12;
    chk("rst_valid", valid_o, 0);
    chk("rst_data", {data_out_r, data_out_i}, 0);
    chk("rst_err", err_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single group then idle: outputs at calls 3..6, then drain completes
    gr = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
    gi = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
    model_group();
    vhist = '0;
    emitted = 0;
    send_group();
    idle(6);
    chk("t1_valid_pattern", vhist[9:0], 10'b0001111000);
    chk("t1_count", emitted, 4);
    chk("t1_queue_empty", expq.size(), 0);
    chk("t1_err", err_o, 0);

    // continuous 32-sample random frame: 32 gap-free outputs
    vhist = '0;
    emitted = 0;
    for (int g = 0; g < 8; g++) begin
      rand_group();
      send_group();
    end
    idle(5);
    chk("t2_contiguous", vhist, {32'hFFFF_FFFF, 2'b00});
    chk("t2_count", emitted, 32);
    chk("t2_queue_empty", expq.size(), 0);
    chk("t2_err", err_o, 0);

    // extremes: full-scale differences must not wrap
    gr = '{-16'sd32768, -16'sd32768, 16'sd32767, 16'sd32767};
    gi = '{16'sd32767, 16'sd32767, -16'sd32768, -16'sd32768};
    model_group();
    emitted = 0;
    send_group();
    idle(4);
    chk("t3_count", emitted, 4);
    chk("t3_last_held", {data_out_r, data_out_i}, {17'sd65535, 17'sd65535});
    chk("t3_err", err_o, 0);

    // stall at cnt=1 in the second group of a back-to-back pair
    emitted = 0;
    rand_group();
    send_group();
    rand_group();
    cyc(1'b1, gr[0], gi[0]);
    cyc(1'b0, '0, '0);
    cyc(1'b1, gr[1], gi[1]);
    chk("t4_stall_valid", valid_o, 0);
    chk("t4_stall_err", err_o, 1);
    cyc(1'b1, gr[2], gi[2]);
    cyc(1'b1, gr[3], gi[3]);
    idle(4);
    chk("t4_count", emitted, 8);
    chk("t4_queue_empty", expq.size(), 0);

    // sample arriving in drain cycle 2 is dropped and flagged
    do_reset();
    chk("t5_err_cleared", err_o, 0);
    emitted = 0;
    rand_group();
    send_group();
    cyc(1'b0, '0, '0);
    cyc(1'b1, 16'($urandom), 16'($urandom));
    idle(4);
    chk("t5_count", emitted, 4);
    chk("t5_queue_empty", expq.size(), 0);
    chk("t5_err", err_o, 1);

    // asynchronous reset during the butterfly phase, then a clean frame
    rand_group();
    for (int k = 0; k < 4; k++) cyc(1'b1, gr[k], gi[k]);
    chk("t6_pre_valid", valid_o, 1);
    #2;
    rst_n = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("t6_async_valid", valid_o, 0);
    chk("t6_async_data", {data_out_r, data_out_i}, 0);
    chk("t6_async_err", err_o, 0);
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    emitted = 0;
    rand_group();
    send_group();
    idle(4);
    chk("t6_count", emitted, 4);
    chk("t6_queue_empty", expq.size(), 0);
    chk("t6_err", err_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
